// File: rtl/tpu_job_sequencer_if.sv
// ---------------------------------------------------------------------------
// tpu_job_sequencer_if
// Bundles the buffer-memory handshakes and the TPU MMIO port driven by the
// job sequencer.
//   master : sequencer side (drives requests and TPU commands)
//   slave  : memory / TPU side (drives grants, read data, TPU read data)
// Signals:
//   mem_rd_req/addr, mem_rd_gnt, mem_rd_valid, mem_rd_data : source reads
//   mem_wr_req/addr/data, mem_wr_gnt                       : destination writes
//   tpu_r_w, tpu_addr, tpu_dataIn, tpu_dataOut             : TPU port
// ---------------------------------------------------------------------------
interface tpu_job_sequencer_if #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16,
    parameter int MEMW  = 32
);
    logic             mem_rd_req;
    logic [MEMW-1:0]  mem_rd_addr;
    logic             mem_rd_gnt;
    logic             mem_rd_valid;
    logic [DATAW-1:0] mem_rd_data;

    logic             mem_wr_req;
    logic [MEMW-1:0]  mem_wr_addr;
    logic [DATAW-1:0] mem_wr_data;
    logic             mem_wr_gnt;

    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    modport master (
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_gnt, mem_rd_valid, mem_rd_data,
        output mem_wr_req, mem_wr_addr, mem_wr_data,
        input  mem_wr_gnt,
        output tpu_r_w, tpu_addr, tpu_dataIn,
        input  tpu_dataOut
    );

    modport slave (
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_gnt, mem_rd_valid, mem_rd_data,
        input  mem_wr_req, mem_wr_addr, mem_wr_data,
        output mem_wr_gnt,
        input  tpu_r_w, tpu_addr, tpu_dataIn,
        output tpu_dataOut
    );
endinterface

// File: rtl/tpu_job_sequencer.sv
// ---------------------------------------------------------------------------
// tpu_job_sequencer
// Runs one 8x8 matmul job on the TPU per go pulse: fetch A and B from the
// source buffer, load them into the TPU, optionally clear C, start the
// matmul, wait, then read C back and store it to the destination buffer.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   go_i, acc_i            : start pulse, accumulate select (sampled in IDLE)
//   src_base_i, dst_base_i : buffer word base addresses (sampled with go_i)
//   busy_o, done_o         : job in progress, single-cycle completion pulse
//   bus                    : memory handshakes and TPU port (master side)
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | waiting for go
// S_RD_REQ   | source read request held until grant
// S_RD_WAIT  | waiting for read data of word idx
// S_LOAD     | one TPU write of the fetched word (A row idx or B push)
// S_CLRC     | TPU write of zero to C half idx (acc = 0 only)
// S_MMSTART  | TPU write to the matmul start address
// S_MMWAIT   | TPU idle while the matmul completes
// S_C_RD     | TPU read of C half idx, data registered at cycle end
// S_WR_REQ   | destination write held until grant
// S_DONE     | done pulse
// ---------------------------------------------------------------------------
module tpu_job_sequencer #(
    parameter int DATAW   = 64,
    parameter int ADDRW   = 16,
    parameter int MEMW    = 32,
    parameter int MM_WAIT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go_i,
    input  logic            acc_i,
    input  logic [MEMW-1:0] src_base_i,
    input  logic [MEMW-1:0] dst_base_i,
    output logic            busy_o,
    output logic            done_o,
    tpu_job_sequencer_if.master bus
);

    localparam int WAITW = $clog2(MM_WAIT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_LOAD, S_CLRC,
        S_MMSTART, S_MMWAIT, S_C_RD, S_WR_REQ, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic             acc_q, acc_d;
    logic [MEMW-1:0]  src_q, src_d;
    logic [MEMW-1:0]  dst_q, dst_d;
    logic [DATAW-1:0] rd_buf_q, rd_buf_d;
    logic [DATAW-1:0] c_buf_q, c_buf_d;
    logic [WAITW-1:0] wait_q, wait_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rd_req_q, rd_req_d;
    logic [MEMW-1:0]  rd_addr_q, rd_addr_d;
    logic             wr_req_q, wr_req_d;
    logic [MEMW-1:0]  wr_addr_q, wr_addr_d;
    logic [DATAW-1:0] wr_data_q, wr_data_d;
    logic             tpu_rw_q, tpu_rw_d;
    logic [ADDRW-1:0] tpu_addr_q, tpu_addr_d;
    logic [DATAW-1:0] tpu_din_q, tpu_din_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            acc_q      <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            rd_buf_q   <= '0;
            c_buf_q    <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            tpu_rw_q   <= 1'b0;
            tpu_addr_q <= '0;
            tpu_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rd_buf_q   <= rd_buf_d;
            c_buf_q    <= c_buf_d;
            wait_q     <= wait_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
            wr_req_q   <= wr_req_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tpu_rw_q   <= tpu_rw_d;
            tpu_addr_q <= tpu_addr_d;
            tpu_din_q  <= tpu_din_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rd_buf_d = rd_buf_q;
        c_buf_d  = c_buf_q;
        wait_d   = wait_q;

        case (state_q)
            S_IDLE: begin
                if (go_i) begin
                    acc_d   = acc_i;
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    idx_d   = '0;
                    state_d = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                if (bus.mem_rd_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (bus.mem_rd_valid) begin
                    rd_buf_d = bus.mem_rd_data;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (idx_q == 4'd15) begin
                    idx_d   = '0;
                    state_d = acc_q ? S_MMSTART : S_CLRC;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_RD_REQ;
                end
            end
            S_CLRC: begin
                if (idx_q == 4'd15) begin
                    idx_d   = '0;
                    state_d = S_MMSTART;
                end else begin
                    idx_d   = idx_q + 4'd1;
                end
            end
            S_MMSTART: begin
                wait_d  = WAITW'(MM_WAIT - 1);
                state_d = S_MMWAIT;
            end
            S_MMWAIT: begin
                if (wait_q == '0) begin
                    idx_d   = '0;
                    state_d = S_C_RD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_C_RD: begin
                // tpu_addr_q holds the C address this cycle, so dataOut is valid
                c_buf_d = bus.tpu_dataOut;
                state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (bus.mem_wr_gnt) begin
                    if (idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_C_RD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rd_req_d   = 1'b0;
        rd_addr_d  = '0;
        wr_req_d   = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        tpu_rw_d   = 1'b0;
        tpu_addr_d = '0;
        tpu_din_d  = '0;

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

        case (state_d)
            S_RD_REQ: begin
                rd_req_d  = 1'b1;
                rd_addr_d = src_d + MEMW'(idx_d);
            end
            S_LOAD: begin
                tpu_rw_d   = 1'b1;
                tpu_addr_d = idx_d[3] ? ADDRW'(12'h200)
                                      : ADDRW'(12'h100 + {6'd0, idx_d[2:0], 3'd0});
                tpu_din_d  = rd_buf_d;
            end
            S_CLRC: begin
                // idx = 2r + h, so (r<<4 | h<<3) == idx<<3
                tpu_rw_d   = 1'b1;
                tpu_addr_d = ADDRW'(12'h300 + {5'd0, idx_d, 3'd0});
            end
            S_MMSTART: begin
                tpu_rw_d   = 1'b1;
                tpu_addr_d = ADDRW'(12'h400);
            end
            S_C_RD: begin
                tpu_addr_d = ADDRW'(12'h300 + {5'd0, idx_d, 3'd0});
            end
            S_WR_REQ: begin
                wr_req_d  = 1'b1;
                wr_addr_d = dst_d + MEMW'(idx_d);
                wr_data_d = c_buf_d;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign bus.mem_rd_req  = rd_req_q;
    assign bus.mem_rd_addr = rd_addr_q;
    assign bus.mem_wr_req  = wr_req_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.tpu_r_w     = tpu_rw_q;
    assign bus.tpu_addr    = tpu_addr_q;
    assign bus.tpu_dataIn  = tpu_din_q;

endmodule
